// File: rtl/ram16x8_arb_pkg.sv
// Shared types and constants for the dual-port arbitrated 16x8 RAM front end.
package ram16x8_arb_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    // Port indices as used by the picker pointer and the read-return path
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 4'hF;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        S_RST  = 2'b00,
        S_INIT = 2'b01,
        S_RUN  = 2'b10
    } state_e;

    // One-hot per-port strobe for a given port index
    function automatic logic [1:0] port_onehot(input logic port);
        logic [1:0] oh;
        if (port == PORT1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/ram16x8_arb_if.sv
// Command, response and RAM-side signals of the arbitrated RAM front end.
interface ram16x8_arb_if;
    import ram16x8_arb_pkg::*;

    logic  clr;
    logic  req0;
    logic  req1;
    logic  wr0;
    logic  wr1;
    addr_t addr0;
    addr_t addr1;
    data_t wdata0;
    data_t wdata1;
    logic  gnt0;
    logic  gnt1;
    logic  rvalid0;
    logic  rvalid1;
    data_t rdata0;
    data_t rdata1;
    logic  busy;
    addr_t ram_a;
    data_t ram_d;
    logic  ram_we;
    data_t ram_o;

    // Requesters and the external RAM
    modport master (
        output clr, req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_o,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, ram_a, ram_d, ram_we
    );

    // The arbiter itself
    modport slave (
        input  clr, req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_o,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, ram_a, ram_d, ram_we
    );

endinterface

// File: rtl/ram16x8_rr_pick.sv
// Two-way picker: round-robin on the last winner, or fixed priority to port 0.
module ram16x8_rr_pick
    import ram16x8_arb_pkg::*;
#(
    parameter bit PRIO_RR = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic       last_q;
    logic       last_d;
    logic [1:0] gnt_s;

    // Winner selection: a lone requester always wins; a tie goes to the port that lost last time
    always_comb begin
        gnt_s = 2'b00;
        if (!en_i) begin
            gnt_s = 2'b00;
        end else begin
            case (req_i)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11: begin
                    if (PRIO_RR && (last_q == PORT0)) begin
                        gnt_s = 2'b10;
                    end else begin
                        gnt_s = 2'b01;
                    end
                end
                default: gnt_s = 2'b00;
            endcase
        end
    end

    // Pointer follows every grant so the other port is favoured on the next tie
    always_comb begin
        last_d = last_q;
        if (gnt_s[1]) begin
            last_d = PORT1;
        end else if (gnt_s[0]) begin
            last_d = PORT0;
        end else begin
            last_d = last_q;
        end
    end

    // Last-winner register; starts at port 1 so port 0 takes the first tie
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/ram16x8_arb.sv
// Dual-port front end for an external 16x8 RAM with async read and clocked write.
// After reset (or on CLR) the whole RAM is swept to CLR_VAL before commands are granted.
// A command granted in cycle t drives the RAM in t+1; read data is returned in t+2.
module ram16x8_arb
    import ram16x8_arb_pkg::*;
#(
    parameter bit    PRIO_RR = 1'b1,
    parameter data_t CLR_VAL = 8'h00
) (
    input logic          clk_i,
    input logic          rst_n_i,
    ram16x8_arb_if.slave bus
);

    state_e     state_q, state_d;
    addr_t      cnt_q, cnt_d;
    addr_t      ram_a_q, ram_a_d;
    data_t      ram_d_q, ram_d_d;
    logic       ram_we_q, ram_we_d;
    logic       rd_q, rd_d;
    logic       rd_port_q, rd_port_d;
    logic [1:0] rvalid_q, rvalid_d;
    data_t      rdata0_q, rdata0_d;
    data_t      rdata1_q, rdata1_d;
    logic       busy_q, busy_d;
    logic       en_s;
    logic [1:0] gnt_s;

    assign en_s = (state_q == S_RUN) && !bus.clr;

    ram16x8_rr_pick #(
        .PRIO_RR (PRIO_RR)
    ) u_pick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_s),
        .req_i   ({bus.req1, bus.req0}),
        .gnt_o   (gnt_s)
    );

    // Sequencing: reset cycle, clear sweep, then register one granted command per cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_a_d   = ram_a_q;
        ram_d_d   = ram_d_q;
        ram_we_d  = 1'b0;
        rd_d      = 1'b0;
        rd_port_d = rd_port_q;
        case (state_q)
            S_RST: begin
                state_d  = S_INIT;
                cnt_d    = 4'd0;
                ram_a_d  = 4'd0;
                ram_d_d  = CLR_VAL;
                ram_we_d = 1'b1;
            end
            S_INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d    = cnt_q + 4'd1;
                    ram_a_d  = cnt_q + 4'd1;
                    ram_d_d  = CLR_VAL;
                    ram_we_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.clr) begin
                    // The access already in flight still completes on this edge
                    state_d  = S_INIT;
                    cnt_d    = 4'd0;
                    ram_a_d  = 4'd0;
                    ram_d_d  = CLR_VAL;
                    ram_we_d = 1'b1;
                end else if (gnt_s[1]) begin
                    ram_a_d   = bus.addr1;
                    ram_d_d   = bus.wdata1;
                    ram_we_d  = bus.wr1;
                    rd_d      = !bus.wr1;
                    rd_port_d = PORT1;
                end else if (gnt_s[0]) begin
                    ram_a_d   = bus.addr0;
                    ram_d_d   = bus.wdata0;
                    ram_we_d  = bus.wr0;
                    rd_d      = !bus.wr0;
                    rd_port_d = PORT0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
        busy_d = (state_d != S_RUN);
    end

    // Read return: capture the async RAM output at the end of a read access cycle
    always_comb begin
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (rd_q) begin
            rvalid_d = port_onehot(rd_port_q);
            if (rd_port_q == PORT1) begin
                rdata1_d = bus.ram_o;
            end else begin
                rdata0_d = bus.ram_o;
            end
        end else begin
            rvalid_d = 2'b00;
        end
    end

    // State and output registers; reset aborts any access or sweep immediately
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_RST;
            cnt_q     <= 4'd0;
            ram_a_q   <= 4'd0;
            ram_d_q   <= CLR_VAL;
            ram_we_q  <= 1'b0;
            rd_q      <= 1'b0;
            rd_port_q <= PORT0;
            rvalid_q  <= 2'b00;
            rdata0_q  <= 8'h00;
            rdata1_q  <= 8'h00;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ram_a_q   <= ram_a_d;
            ram_d_q   <= ram_d_d;
            ram_we_q  <= ram_we_d;
            rd_q      <= rd_d;
            rd_port_q <= rd_port_d;
            rvalid_q  <= rvalid_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.gnt0    = gnt_s[0];
    assign bus.gnt1    = gnt_s[1];
    assign bus.rvalid0 = rvalid_q[0];
    assign bus.rvalid1 = rvalid_q[1];
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.busy    = busy_q;
    assign bus.ram_a   = ram_a_q;
    assign bus.ram_d   = ram_d_q;
    assign bus.ram_we  = ram_we_q;

endmodule

// File: doc/ram16x8_arb.md
RAM16X8_ARB -- requirements
Module: ram16x8_arb

Interface
REQ-001 SHALL have parameter: PRIO_RR, 1, 1 = round-robin between ports, 0 = fixed priority with port 0 winning.
REQ-002 SHALL have parameter: CLR_VAL, 8'h00, value written to every RAM word during a clear sweep.
REQ-003 SHALL have ports (name direction width meaning):
- CLK  in  1  single clock; also drives the RAM WCLK externally
- RST_N  in  1  asynchronous, active-low reset
- CLR  in  1  start a clear sweep
- REQ0/REQ1  in  1  port request
- WR0/WR1  in  1  1 = write, 0 = read
- ADDR0/ADDR1  in  4  word address
- WDATA0/WDATA1  in  8  write data
- GNT0/GNT1  out  1  command accepted on this edge when REQx=1
- RVALID0/RVALID1  out  1  read data valid, one-cycle pulse
- RDATA0/RDATA1  out  8  read data
- BUSY  out  1  clear/reset sequence in progress
- RAM_A  out  4  RAM address (A3..A0)
- RAM_D  out  8  RAM write data
- RAM_WE  out  1  RAM write enable
- RAM_O  in  8  RAM asynchronous read data

Function
REQ-004 SHALL implement state machine S_RST -> S_INIT -> S_RUN; S_RST lasts exactly one cycle after reset release.
REQ-005 S_INIT SHALL write CLR_VAL to addresses 0..15 in order, one per cycle (16 cycles), then enter S_RUN.
REQ-006 BUSY SHALL be 1 in S_RST and S_INIT, 0 in S_RUN.
REQ-007 GNT0/GNT1 SHALL be combinational, at most one high, and both 0 unless state is S_RUN and CLR=0.
REQ-008 With one port requesting, that port SHALL be granted in the same cycle.
REQ-009 With both requesting and PRIO_RR=1, the port not granted most recently SHALL win; the last-winner pointer resets to port 1, so port 0 wins first.
REQ-010 With PRIO_RR=0, port 0 SHALL always win a tie.
REQ-011 A requester SHALL hold REQ/WR/ADDR/WDATA stable until it sees GNT; a command is accepted on the edge where REQx&GNTx=1.
REQ-012 An accepted command SHALL be registered and drive RAM_A/RAM_D/RAM_WE in the following (access) cycle; a write commits on the edge ending that cycle.
REQ-013 For a read, RAM_O SHALL be captured at the end of the access cycle; RDATAx is valid and RVALIDx=1 for exactly one cycle, two cycles after acceptance.
REQ-014 Throughput SHALL be one command per cycle with back-to-back grants; a read immediately following a write to the same address SHALL return the new data.
REQ-015 RDATAx SHALL hold its last value when RVALIDx=0.
REQ-016 CLR=1 in S_RUN SHALL block new grants that cycle; any command already in its access cycle completes, including its RVALID; S_INIT then starts on the next edge.
REQ-017 CLR asserted during S_INIT SHALL be ignored; the sweep is not restarted.
REQ-018 Outside S_INIT and access cycles, RAM_WE SHALL be 0.

Reset
REQ-019 RST_N low SHALL asynchronously force:
- state S_RST
- GNT0/GNT1=0
- RVALID0/RVALID1=0
- RDATA0/RDATA1=8'h00
- BUSY=1
- RAM_WE=0, RAM_A=0, RAM_D=CLR_VAL
- sweep counter 0
- last-winner pointer = port 1
REQ-020 Reset asserted mid-access or mid-sweep SHALL abort the operation with no further RAM write; the full sweep reruns after release.

Structure
REQ-021 A shared package SHALL hold the state enumeration, the port-index constants, and the 4-bit address and 8-bit data width constants.
REQ-022 The block SHALL contain one sub-module, ram16x8_rr_pick: a 2-way round-robin/priority picker with pointer register.
REQ-023 The RAM itself SHALL be instantiated outside this block.

Verification
REQ-024 Reset release: BUSY falls after 17 edges, RAM_WE=1 for 16 consecutive cycles covering addresses 0..15, then all 16 reads return CLR_VAL=8'hA5.
REQ-025 Port 0 writes 8'h3C to address 4, then reads address 4 back-to-back: GNT0 on both cycles, RVALID0 two cycles after the read with RDATA0=8'h3C.
REQ-026 Both ports request continuously with PRIO_RR=1: grants alternate 0,1,0,1; with PRIO_RR=0 only GNT0 asserts.
REQ-027 CLR pulsed while port 1 is reading address 9 (accepted the previous cycle): RVALID1 delivers the old data, no grants for 17 cycles, BUSY=1, then address 9 reads CLR_VAL.
REQ-028 RST_N dropped during the sweep at address 7: outputs take reset values immediately, the sweep restarts at address 0 after release.
REQ-029 Port 1 write to address 15 followed by a port 0 read of address 15: the read returns the written data.
